// File: rtl/debug_pkg.sv
// Shared definitions for the debug controller access path: master FSM states,
// debug slave register map and the packed host command.
package debug_pkg;

  // Native widths of the debug controller's slave port.
  localparam int unsigned DBG_ADDR_W = 3;
  localparam int unsigned DBG_DATA_W = 32;

  // Debug slave register offsets (word addresses).
  localparam logic [DBG_ADDR_W-1:0] DBG_REG_CTRL  = 3'd0;
  localparam logic [DBG_ADDR_W-1:0] DBG_REG_IADDR = 3'd1;
  localparam logic [DBG_ADDR_W-1:0] DBG_REG_EADDR = 3'd2;
  localparam int unsigned           DBG_CTRL_EN_BIT = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    READ   = 3'd2,
    RDWAIT = 3'd3,
    RESP   = 3'd4
  } dbg_state_e;

  typedef struct packed {
    logic                  write;
    logic [DBG_ADDR_W-1:0] addr;
    logic [DBG_DATA_W-1:0] wdata;
  } dbg_cmd_t;

endpackage

// File: rtl/avalon_debug_master.sv
// Single-outstanding Avalon-MM master driving the debug controller slave port.
// Optional waitrequest timeout: define AVALON_DEBUG_MASTER_TIMEOUT_EN.
module avalon_debug_master
  import debug_pkg::*;
#(
  parameter int unsigned ADDR_W         = 3,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              av_chipselect,
  output logic              av_write,
  output logic              av_read,
  output logic [ADDR_W-1:0] av_address,
  output logic [DATA_W-1:0] av_writedata,
  input  logic [DATA_W-1:0] av_readdata,
  input  logic              av_waitrequest,
  output logic              busy
);

  if (ADDR_W != DBG_ADDR_W || DATA_W != DBG_DATA_W) begin : g_width_chk
    $error("avalon_debug_master: ADDR_W/DATA_W must match the debug slave port");
  end
  if (READ_LATENCY > 7) begin : g_lat_chk
    $error("avalon_debug_master: READ_LATENCY must be 0..7");
  end

  dbg_state_e        state_q, state_d;
  dbg_cmd_t          cmd_q, cmd_d;
  logic [2:0]        lat_q, lat_d;
  logic              cmd_ready_d, rsp_valid_d, rsp_write_d, busy_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              av_cs_d, av_write_d, av_read_d;
  logic              rsp_err_d;
  logic              timed_out;

  // Address/data outputs come straight from the command register, which is
  // cleared when the transfer ends so the bus is quiet outside strobes.
  assign av_address   = cmd_q.addr;
  assign av_writedata = cmd_q.wdata;

`ifdef AVALON_DEBUG_MASTER_TIMEOUT_EN
  if (TIMEOUT_CYCLES < 1) begin : g_to_chk
    $error("avalon_debug_master: TIMEOUT_CYCLES must be at least 1");
  end
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_q, to_d;
  logic            rsp_err_q;

  // The count reaching its limit while still stalled aborts; a low
  // waitrequest on that same edge wins and completes the transfer.
  assign timed_out = av_waitrequest && (to_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err   = rsp_err_q;

  always_comb begin
    to_d = to_q;
    if (state_q == IDLE) to_d = '0;
    else if ((state_q == WRITE || state_q == READ) && av_waitrequest && !timed_out)
      to_d = to_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      to_q      <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      to_q      <= to_d;
      rsp_err_q <= rsp_err_d;
    end
  end
`else
  if (TIMEOUT_CYCLES < 1) begin : g_to_chk
    $error("avalon_debug_master: TIMEOUT_CYCLES must be at least 1");
  end
  assign timed_out = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    lat_d       = lat_q;
    cmd_ready_d = cmd_ready;
    rsp_valid_d = rsp_valid;
    rsp_write_d = rsp_write;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    av_cs_d     = av_chipselect;
    av_write_d  = av_write;
    av_read_d   = av_read;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_d.write = cmd_write;
          cmd_d.addr  = cmd_addr;
          cmd_d.wdata = cmd_write ? cmd_wdata : '0;
          cmd_ready_d = 1'b0;
          av_cs_d     = 1'b1;
          av_write_d  = cmd_write;
          av_read_d   = !cmd_write;
          state_d     = cmd_write ? WRITE : READ;
        end
      end
      WRITE, READ: begin
        if (!av_waitrequest || timed_out) begin
          av_cs_d     = 1'b0;
          av_write_d  = 1'b0;
          av_read_d   = 1'b0;
          cmd_d.addr  = '0;
          cmd_d.wdata = '0;
          rsp_write_d = cmd_q.write;
          rsp_rdata_d = '0;
          rsp_err_d   = timed_out;
          if (state_q == READ && !timed_out && READ_LATENCY != 0) begin
            lat_d   = 3'd1;
            state_d = RDWAIT;
          end else begin
            if (state_q == READ && !timed_out) rsp_rdata_d = av_readdata;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
        end
      end
      RDWAIT: begin
        if (lat_q == 3'(READ_LATENCY)) begin
          rsp_rdata_d = av_readdata;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_d       = '0;
        lat_d       = '0;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_write_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        av_cs_d     = 1'b0;
        av_write_d  = 1'b0;
        av_read_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      lat_q         <= '0;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      av_chipselect <= 1'b0;
      av_write      <= 1'b0;
      av_read       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      lat_q         <= lat_d;
      cmd_ready     <= cmd_ready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_write     <= rsp_write_d;
      rsp_rdata     <= rsp_rdata_d;
      av_chipselect <= av_cs_d;
      av_write      <= av_write_d;
      av_read       <= av_read_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: doc/avalon_debug_master.md
Name: avalon_debug_master

Overview:
Avalon-MM master that drives the debug controller's slave port (control/address registers) on behalf of a host command channel (UART/JTAG bridge or testbench). It accepts one read or write command over a valid/ready handshake and runs it as a single Avalon-MM transfer, honouring waitrequest and a fixed read latency. It returns one response per command. Only one transaction is outstanding at a time.

Parameters:
ADDR_W, 3, Avalon word-address width (matches debug slave address).
DATA_W, 32, data width.
READ_LATENCY, 1, cycles from the read-accept edge (waitrequest low) to valid readdata; range 0..7.
TIMEOUT_CYCLES, 255, waitrequest-high cycles before abort; used only with the optional feature.

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target register address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  host accepts the response
rsp_write  out  1  echo of command type
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_err  out  1  transaction aborted
av_chipselect  out  1  Avalon chipselect
av_write  out  1  Avalon write
av_read  out  1  Avalon read
av_address  out  ADDR_W  Avalon address
av_writedata  out  DATA_W  Avalon write data
av_readdata  in  DATA_W  Avalon read data
av_waitrequest  in  1  slave stall
busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered (Moore). On reset: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_write=0, rsp_err=0, rsp_rdata=0, all av_* = 0, busy=0.
- FSM states: IDLE, WRITE, READ, RDWAIT, RESP.
- IDLE: cmd_ready=1. On the edge where cmd_valid&cmd_ready are both high:
  - latch address, data and type;
  - next state is WRITE or READ;
  - cmd_ready drops on that edge.
- WRITE: av_chipselect=1, av_write=1, with av_address and av_writedata held stable.
  - Edge with av_waitrequest=0: transfer done; next state RESP with rsp_write=1, rsp_rdata=0, rsp_err=0.
  - av_* deassert on the same edge, so a zero-wait write shows strobes for exactly 1 cycle.
- READ: av_chipselect=1, av_read=1 until the edge with av_waitrequest=0.
  - READ_LATENCY=0: capture av_readdata on that edge and go to RESP.
  - Otherwise: deassert strobes, lat_cnt<=1, go to RDWAIT.
- RDWAIT: av_* low. Each edge:
  - if lat_cnt==READ_LATENCY: capture av_readdata into rsp_rdata, go to RESP;
  - else lat_cnt++.
  - Readdata is therefore sampled exactly READ_LATENCY edges after the accept edge.
- RESP: rsp_valid=1 with rsp_* held stable; cmd_ready=0.
  - On rsp_ready=1: rsp_valid<=0, cmd_ready<=1, go to IDLE.
  - Earliest next command acceptance is the cycle after the response handshake; no bypass.
- Back-to-back: minimum 3 cycles per zero-wait write (IDLE, WRITE, RESP).
- cmd_valid held while busy is ignored; it is not consumed until cmd_ready=1.
- Reset mid-transaction: immediate return to IDLE with reset values; the in-flight transfer is abandoned and no response is issued.
- Invalid state encoding recovers to IDLE.

Optional Feature:
Macro: AVALON_DEBUG_MASTER_TIMEOUT_EN.
- Defined:
  - a timeout counter clears on entry to WRITE/READ and increments each cycle that av_waitrequest=1;
  - when it reaches TIMEOUT_CYCLES with waitrequest still high, strobes drop and the FSM goes to RESP with rsp_err=1 and rsp_rdata=0;
  - a transfer accepted on the same edge as the count is reached completes normally, with rsp_err=0.
- Undefined: no counter is built, the block waits indefinitely, and rsp_err is tied to 0 (the port remains).

Decomposition:
- Shared package debug_pkg:
  - FSM state enum;
  - debug register offsets (DBG_REG_CTRL=0 with bit0 = debug enable, DBG_REG_IADDR=1, DBG_REG_EADDR=2);
  - the command struct packing write/addr/wdata.
- No sub-module: the FSM, latency counter and timeout counter form a single module.

Test Plan:
- Write addr 0, data 0x1, waitrequest=0 -> av_chipselect=av_write=1 for exactly 1 cycle with av_address=0, av_writedata=0x1; rsp_valid=1 next cycle with rsp_write=1, rsp_err=0.
- Write addr 1, data 0x0000_0400, waitrequest high 3 cycles -> strobes stay high 4 cycles with stable address/data; one response only.
- Read addr 2, READ_LATENCY=1, slave returns 0xDEADBEEF one cycle after accept -> rsp_rdata=0xDEADBEEF, rsp_write=0; av_read high for exactly 1 cycle.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata held, cmd_ready=0, a pending cmd_valid is not accepted until the cycle after the handshake.
- RST asserted while in READ with waitrequest=1 -> next cycle all av_*=0, rsp_valid=0, cmd_ready=1, busy=0; no response after release.
- With AVALON_DEBUG_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, waitrequest stuck high on a read -> strobes drop after 4 stalled cycles; rsp_valid=1, rsp_err=1, rsp_rdata=0.
